// File: rtl/sigmoid.sv
// Piecewise-constant Q8.8 sigmoid: thermometer compare against 121 breakpoints, LUT lookup, 1-cycle latency.
// Optional build macro SIGMOID_NEAREST_EN rounds to the nearest interior breakpoint instead of flooring.
module sigmoid #(
  parameter int N_ENTRIES = 121,
  parameter int WIDTH     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             done,
  input  logic [WIDTH-1:0] sig_in,
  output logic [WIDTH-1:0] sig_out,
  output logic             sig_ready
);

  localparam int IDX_W = $clog2(N_ENTRIES);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_ENTRIES - 1);

  // Table storage is filled externally at load time and only read here.
  logic [WIDTH-1:0] x   [0:N_ENTRIES-1];
  logic [WIDTH-1:0] LUT [0:N_ENTRIES-1];

  logic [N_ENTRIES-1:0] ge;
  logic [IDX_W-1:0]     idx_floor;
  logic [IDX_W-1:0]     idx_sel;

  always_comb begin
    ge = '0;
    for (int i = 0; i < N_ENTRIES; i++) begin
      ge[i] = ($signed(sig_in) >= $signed(x[i]));
    end
  end

  // Breakpoints ascend, so ge is a thermometer; highest set bit is the floor index.
  // Below x[0] nothing is set and the index clamps to 0.
  always_comb begin
    idx_floor = '0;
    for (int i = 1; i < N_ENTRIES; i++) begin
      if (ge[i]) idx_floor = IDX_W'(i);
    end
  end

`ifdef SIGMOID_NEAREST_EN
  logic signed [WIDTH:0] d_hi;
  logic signed [WIDTH:0] d_lo;
  logic [WIDTH-1:0]      x_hi;
  logic [WIDTH-1:0]      x_lo;

  always_comb begin
    x_hi    = (idx_floor < IDX_LAST) ? x[idx_floor + IDX_W'(1)] : x[idx_floor];
    x_lo    = x[idx_floor];
    d_hi    = $signed({x_hi[WIDTH-1], x_hi}) - $signed({sig_in[WIDTH-1], sig_in});
    d_lo    = $signed({sig_in[WIDTH-1], sig_in}) - $signed({x_lo[WIDTH-1], x_lo});
    idx_sel = idx_floor;
    // Ties and both clamped ends keep the floor index.
    if ((idx_floor != '0) && (idx_floor < IDX_LAST) && (d_hi < d_lo)) begin
      idx_sel = idx_floor + IDX_W'(1);
    end
  end
`else
  always_comb begin
    idx_sel = idx_floor;
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      sig_out   <= '0;
      sig_ready <= 1'b0;
    end else if (done) begin
      sig_out   <= LUT[idx_sel];
      sig_ready <= 1'b1;
    end else begin
      sig_ready <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sigmoid.sv
// Randomized self-checking bench for sigmoid; tables are computed here and written into the DUT memories.
`timescale 1ns/1ps
module tb_sigmoid;

  logic        clk;
  logic        reset;
  logic        done;
  logic [15:0] sig_in;
  logic [15:0] sig_out;
  logic        sig_ready;

  int n_tests = 0;
  int n_fail  = 0;

  int xt [0:120];
  int lt [0:120];

  logic [15:0] exp_out = 16'h0000;
  logic        exp_rdy = 1'b0;

  sigmoid dut (
    .clk       (clk),
    .reset     (reset),
    .done      (done),
    .sig_in    (sig_in),
    .sig_out   (sig_out),
    .sig_ready (sig_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s got=0x%04h expected=0x%04h", tag, got, want);
    end
  endtask

  function automatic int rnd(input real v);
    if (v >= 0.0) return $rtoi(v + 0.5);
    else return -$rtoi(-v + 0.5);
  endfunction

  // Reference index: linear search from the spec's floor/clamp rule, plus optional nearest step.
  function automatic int model_idx(input logic [15:0] s);
    int v;
    int k;
    v = int'($signed(s));
    if (v < xt[0]) return 0;
    k = 120;
    while (xt[k] > v) k--;
`ifdef SIGMOID_NEAREST_EN
    if (k > 0 && k < 120 && (xt[k+1] - v) < (v - xt[k])) k++;
`endif
    return k;
  endfunction

  task automatic step(input string tag, input logic r, input logic d, input logic [15:0] s);
    @(negedge clk);
    reset  = r;
    done   = d;
    sig_in = s;
    @(posedge clk);
    if (r) begin
      exp_out = 16'h0000;
      exp_rdy = 1'b0;
    end else if (d) begin
      exp_out = 16'(lt[model_idx(s)]);
      exp_rdy = 1'b1;
    end else begin
      exp_rdy = 1'b0;
    end
    #1;
    chk({tag, "_out"}, sig_out, exp_out);
    chk({tag, "_rdy"}, {15'd0, sig_ready}, {15'd0, exp_rdy});
  endtask

  initial begin
    real xr;
    reset  = 1'b1;
    done   = 1'b1;
    sig_in = 16'h0000;

    for (int i = 0; i <= 120; i++) begin
      xr    = -6.0 + 0.1 * i;
      xt[i] = rnd(xr * 256.0);
      lt[i] = rnd(256.0 / (1.0 + $exp(-xr)));
      dut.x[i]   = 16'(xt[i]);
      dut.LUT[i] = 16'(lt[i]);
    end

    for (int i = 0; i < 3; i++) step("rst_hold", 1'b1, 1'b1, 16'($urandom));

    step("s0083", 1'b0, 1'b1, 16'h0083);
    chk("dir_0083", sig_out, 16'h009F);
    step("s036e", 1'b0, 1'b1, 16'h036E);
    chk("dir_036e", sig_out, 16'h00F8);
    step("s0680", 1'b0, 1'b1, 16'h0680);
    chk("dir_0680", sig_out, 16'h00FF);
    step("sfd00", 1'b0, 1'b1, 16'hFD00);
    chk("dir_fd00", sig_out, 16'h000C);
    step("s8000", 1'b0, 1'b1, 16'h8000);
    chk("dir_8000", sig_out, 16'h0001);
    step("s0093", 1'b0, 1'b1, 16'h0093);

    step("idle_x", 1'b0, 1'b0, 16'hxxxx);
    step("idle_x2", 1'b0, 1'b0, 16'hxxxx);
    step("rst_pulse", 1'b1, 1'b0, 16'h0083);
    step("post_rst", 1'b0, 1'b1, 16'h0083);
    step("post_rst_idle", 1'b0, 1'b0, 16'h036E);

    for (int i = 0; i <= 120; i++) begin
      step("bp_eq", 1'b0, 1'b1, 16'(xt[i]));
      step("bp_m1", 1'b0, 1'b1, 16'(xt[i] - 1));
      step("bp_p1", 1'b0, 1'b1, 16'(xt[i] + 1));
    end

    for (int i = 0; i < 400; i++) begin
      logic [15:0] s;
      if ($urandom_range(0, 3) == 0) s = 16'($urandom);
      else s = 16'($signed($urandom_range(0, 3584)) - 1792);
      step("rand", ($urandom_range(0, 99) < 3), ($urandom_range(0, 99) < 75), s);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
